// File: rtl/ram_pkg.sv
// Shared defaults and bus-cycle decoding for the glue-logic RAM.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH_DEF = 8;
    localparam int RAM_DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } bus_op_e;

    // Reset dominates, then chip select, then direction.
    function automatic bus_op_e decode_op(input logic rst_n, input logic enable, input logic write);
        bus_op_e op;
        if (!rst_n) begin
            op = OP_IDLE;
        end else if (!enable) begin
            op = OP_IDLE;
        end else if (write) begin
            op = OP_WRITE;
        end else begin
            op = OP_READ;
        end
        return op;
    endfunction

endpackage

// File: rtl/ram_if.sv
// Address and strobe group of the 68k glue bus; the shared data bus stays a plain inout net.
interface ram_if #(
    parameter int ADDR_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic                  enable;
    logic                  write;

    modport master (output addr, output enable, output write);
    modport slave  (input  addr, input  enable, input  write);

endinterface

// File: rtl/ram_bus_driver.sv
// Tri-state buffer onto the shared data bus; released whenever oe_i is low.
module ram_bus_driver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  oe_i,
    input  logic [DATA_WIDTH-1:0] rd_word_i,
    inout  wire  [DATA_WIDTH-1:0] data
);

    assign data = oe_i ? rd_word_i : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/ram.sv
// Single-port word RAM: clocked writes from the shared bus, combinational reads back onto it.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_if.slave            bus,
    inout  wire  [DATA_WIDTH-1:0] data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    bus_op_e               op_s;
    logic                  oe_s;
    logic                  we_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    assign op_s      = decode_op(rst_n, bus.enable, bus.write);
    assign oe_s      = (op_s == OP_READ);
    assign we_s      = (op_s == OP_WRITE);
    assign rd_word_s = mem_q[bus.addr];

    // Memory array: cleared while in reset, otherwise captures the bus on a write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we_s) begin
            mem_q[bus.addr] <= data;
        end
    end

    ram_bus_driver #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bus_driver (
        .oe_i      (oe_s),
        .rd_word_i (rd_word_s),
        .data      (data)
    );

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: the data bus is weakly pulled high so a released bus reads 0xFF.
module tb_ram;

    logic       clk;
    logic       rst_n;
    logic       tb_drv;
    logic [7:0] tb_val;
    tri1  [7:0] data;
    int         checks;
    int         errors;

    ram_if #(.ADDR_WIDTH(8)) bus ();

    assign data = tb_drv ? tb_val : {8{1'bz}};

    ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr   = a;
        bus.write  = 1'b1;
        bus.enable = 1'b1;
        tb_val     = d;
        tb_drv     = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        bus.write  = 1'b0;
        tb_drv     = 1'b0;
    endtask

    task automatic start_read(input logic [7:0] a);
        @(negedge clk);
        tb_drv     = 1'b0;
        bus.write  = 1'b0;
        bus.addr   = a;
        bus.enable = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        bus.enable = 1'b1;
        #1;
        checks++;
        if (data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_bus_released got %h expected %h", data, 8'hFF);
        end
        rst_n = 1'b1;
        start_read(8'h00);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_clear_00 got %h expected %h", data, 8'h00); end
        start_read(8'h01);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_clear_01 got %h expected %h", data, 8'h00); end
        start_read(8'hFF);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL reset_clear_ff got %h expected %h", data, 8'h00); end
        bus.enable = 1'b0;
        #1;
        checks++;
        if (data !== 8'hFF) begin errors++; $display("FAIL reset_idle_z got %h expected %h", data, 8'hFF); end
    endtask

    task automatic test_basic();
        write_word(8'h01, 8'h80);
        write_word(8'h02, 8'h81);
        start_read(8'h01);
        checks++;
        if (data !== 8'h80) begin errors++; $display("FAIL basic_rd_01 got %h expected %h", data, 8'h80); end
        start_read(8'h02);
        checks++;
        if (data !== 8'h81) begin errors++; $display("FAIL basic_rd_02 got %h expected %h", data, 8'h81); end
        bus.enable = 1'b0;
    endtask

    task automatic test_tristate();
        @(negedge clk);
        bus.enable = 1'b0;
        bus.addr   = 8'h01;
        tb_drv     = 1'b0;
        #2;
        checks++;
        if (data !== 8'hFF) begin errors++; $display("FAIL tri_idle got %h expected %h", data, 8'hFF); end
        @(negedge clk);
        bus.addr   = 8'h02;
        bus.write  = 1'b1;
        bus.enable = 1'b1;
        tb_val     = 8'h5C;
        tb_drv     = 1'b1;
        #2;
        checks++;
        if (data !== 8'h5C) begin errors++; $display("FAIL tri_write_cycle got %h expected %h", data, 8'h5C); end
        @(negedge clk);
        bus.enable = 1'b0;
        bus.write  = 1'b0;
        tb_drv     = 1'b0;
        start_read(8'h02);
        checks++;
        if (data !== 8'h5C) begin errors++; $display("FAIL tri_write_stored got %h expected %h", data, 8'h5C); end
        bus.enable = 1'b0;
    endtask

    task automatic test_boundaries();
        write_word(8'h00, 8'hA5);
        write_word(8'hFF, 8'h5A);
        // Strobe with enable low must not touch memory.
        @(negedge clk);
        bus.addr   = 8'h7F;
        bus.write  = 1'b1;
        bus.enable = 1'b0;
        tb_val     = 8'h99;
        tb_drv     = 1'b1;
        @(negedge clk);
        bus.write  = 1'b0;
        tb_drv     = 1'b0;
        start_read(8'h00);
        checks++;
        if (data !== 8'hA5) begin errors++; $display("FAIL bound_rd_00 got %h expected %h", data, 8'hA5); end
        start_read(8'hFF);
        checks++;
        if (data !== 8'h5A) begin errors++; $display("FAIL bound_rd_ff got %h expected %h", data, 8'h5A); end
        start_read(8'h7F);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL bound_rd_7f got %h expected %h", data, 8'h00); end
        bus.enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.addr   = 8'h10;
        bus.write  = 1'b1;
        bus.enable = 1'b1;
        tb_val     = 8'h11;
        tb_drv     = 1'b1;
        @(negedge clk);
        tb_val     = 8'h22;
        @(negedge clk);
        // Drop write while enable held: becomes a read.
        tb_drv     = 1'b0;
        bus.write  = 1'b0;
        #2;
        checks++;
        if (data !== 8'h22) begin errors++; $display("FAIL b2b_overwrite got %h expected %h", data, 8'h22); end
        bus.enable = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        write_word(8'h05, 8'h44);
        start_read(8'h05);
        checks++;
        if (data !== 8'h44) begin errors++; $display("FAIL mid_prewrite got %h expected %h", data, 8'h44); end
        @(negedge clk);
        bus.write  = 1'b1;
        tb_val     = 8'h33;
        tb_drv     = 1'b1;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tb_drv    = 1'b0;
        bus.write = 1'b0;
        #1;
        checks++;
        if (data !== 8'hFF) begin errors++; $display("FAIL mid_bus_released got %h expected %h", data, 8'hFF); end
        @(negedge clk);
        rst_n = 1'b1;
        start_read(8'h05);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL mid_cleared got %h expected %h", data, 8'h00); end
        start_read(8'h00);
        checks++;
        if (data !== 8'h00) begin errors++; $display("FAIL mid_cleared_00 got %h expected %h", data, 8'h00); end
        bus.enable = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        tb_drv     = 1'b0;
        tb_val     = 8'h00;
        bus.addr   = 8'h00;
        bus.enable = 1'b0;
        bus.write  = 1'b0;
        test_reset();
        test_basic();
        test_tristate();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
